dcache_ctrl_fsm: RTL and testbench

Direct-mapped, write-back, write-allocate L1 data-cache controller between the pipeline MEM stage and the off-chip data memory. It holds the tag, valid and dirty arrays and a register-based data array, and serves hits with zero added latency. On a miss it stalls the pipeline, writes back a dirty victim, and refills the line from memory over a req/ack handshake.

---
 rtl/dcache_pkg.sv | 37 +++
 rtl/dcache_tag_store.sv | 47 ++++
 rtl/dcache_ctrl_fsm.sv | 120 ++++++++++++
 tb/tb_dcache_ctrl_fsm.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types, widths and address-field helpers for the
// direct-mapped write-back L1 data cache.
package dcache_pkg;

  localparam int ADDR_W         = 32;
  localparam int INDEX_W        = 4;
  localparam int OFFSET_W       = 5;
  localparam int TAG_W          = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINE_W         = 256;
  localparam int WORDS_PER_LINE = 8;
  localparam int NLINES         = 1 << INDEX_W;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    REFILL
  } state_e;

  function automatic logic [TAG_W-1:0] addr_tag(
    input logic [ADDR_W-1:0] a
  );
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(
    input logic [ADDR_W-1:0] a
  );
    return a[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [2:0] addr_word(
    input logic [ADDR_W-1:0] a
  );
    return a[4:2];
  endfunction

endpackage

// File: rtl/dcache_tag_store.sv
// Valid/dirty/tag arrays: valid and dirty reset asynchronously,
// tags are plain storage qualified by valid.
module dcache_tag_store
  import dcache_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [INDEX_W-1:0] lk_idx_i,
  output logic               lk_valid_o,
  output logic               lk_dirty_o,
  output logic [TAG_W-1:0]   lk_tag_o,
  input  logic               fill_i,
  input  logic               set_dirty_i,
  input  logic [INDEX_W-1:0] upd_idx_i,
  input  logic [TAG_W-1:0]   upd_tag_i
);

  logic [NLINES-1:0] valid_q;
  logic [NLINES-1:0] dirty_q;
  logic [TAG_W-1:0]  tag_q [NLINES];

  assign lk_valid_o = valid_q[lk_idx_i];
  assign lk_dirty_o = dirty_q[lk_idx_i];
  assign lk_tag_o   = tag_q[lk_idx_i];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (fill_i) begin
        valid_q[upd_idx_i] <= 1'b1;
        dirty_q[upd_idx_i] <= 1'b0;
      end
      if (set_dirty_i) begin
        dirty_q[upd_idx_i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill_i) begin
      tag_q[upd_idx_i] <= upd_tag_i;
    end
  end

endmodule

// File: rtl/dcache_ctrl_fsm.sv
// L1 data-cache controller: zero-latency hits, stall on miss,
// dirty-victim write-back then line refill over req/ack.
module dcache_ctrl_fsm
  import dcache_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              cpu_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);

  state_e             state_q, state_d;
  logic [TAG_W-1:0]   miss_tag_q, miss_tag_d;
  logic [INDEX_W-1:0] miss_idx_q, miss_idx_d;
  logic [LINE_W-1:0]  data_q [NLINES];

  logic               idle;
  logic [INDEX_W-1:0] lk_idx;
  logic               lk_valid;
  logic               lk_dirty;
  logic [TAG_W-1:0]   lk_tag;
  logic [TAG_W-1:0]   cpu_tag;
  logic [7:0]         bit_off;
  logic [LINE_W-1:0]  line;
  logic               hit;
  logic               wr_hit;
  logic               fill;
  logic [1:0]         unused_addr;

  assign unused_addr = cpu_addr_i[1:0];

  assign idle    = (state_q == IDLE);
  assign cpu_tag = addr_tag(cpu_addr_i);
  assign bit_off = {addr_word(cpu_addr_i), 5'b00000};
  // Miss handling uses the latched index, so a dropped request still completes
  assign lk_idx  = idle ? addr_index(cpu_addr_i) : miss_idx_q;
  assign line    = data_q[lk_idx];

  assign hit = cpu_req_i & lk_valid & (lk_tag == cpu_tag) & idle;
  assign wr_hit      = hit & cpu_we_i;
  assign fill        = (state_q == REFILL) & mem_ack_i;
  assign cpu_stall_o = cpu_req_i & ~hit;
  assign cpu_rdata_o = hit ? line[bit_off +: 32] : 32'h0;

  dcache_tag_store u_tags (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .lk_idx_i    (lk_idx),
    .lk_valid_o  (lk_valid),
    .lk_dirty_o  (lk_dirty),
    .lk_tag_o    (lk_tag),
    .fill_i      (fill),
    .set_dirty_i (wr_hit),
    .upd_idx_i   (lk_idx),
    .upd_tag_i   (miss_tag_q)
  );

  always_comb begin
    state_d     = state_q;
    miss_tag_d  = miss_tag_q;
    miss_idx_d  = miss_idx_q;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    unique case (state_q)
      IDLE: begin
        if (cpu_req_i && !hit) begin
          miss_tag_d = cpu_tag;
          miss_idx_d = addr_index(cpu_addr_i);
          state_d = (lk_valid && lk_dirty) ? WRITEBACK : REFILL;
        end
      end
      WRITEBACK: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {lk_tag, lk_idx, {OFFSET_W{1'b0}}};
        mem_wdata_o = line;
        if (mem_ack_i) state_d = REFILL;
      end
      REFILL: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {miss_tag_q, lk_idx, {OFFSET_W{1'b0}}};
        if (mem_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      miss_tag_q <= miss_tag_d;
      miss_idx_q <= miss_idx_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill) begin
      data_q[lk_idx] <= mem_rdata_i;
    end else if (wr_hit) begin
      data_q[lk_idx][bit_off +: 32] <= cpu_wdata_i;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl_fsm.sv
// Directed self-checking bench for dcache_ctrl_fsm.
// Linear stimulus, immediate assertions at each check point.
module tb_dcache_ctrl_fsm;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i;
  logic         cpu_we_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_wdata_i;
  logic [31:0]  cpu_rdata_o;
  logic         cpu_stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_wdata_o;
  logic [255:0] mem_rdata_i;
  logic         mem_ack_i;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  dcache_ctrl_fsm dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_rdata_o (cpu_rdata_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i)
  );

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [255:0] mk_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  logic [255:0] l1;

  initial begin
    rst_i       = 1'b1;
    cpu_req_i   = 1'b0;
    cpu_we_i    = 1'b0;
    cpu_addr_i  = 32'h0;
    cpu_wdata_i = 32'h0;
    mem_rdata_i = '0;
    mem_ack_i   = 1'b0;
    #2;
    chk("rst_stall_idle", cpu_stall_o, 0);
    chk("rst_mem_req", mem_req_o, 0);
    cpu_req_i  = 1'b1;
    cpu_addr_i = 32'h40;
    #1;
    chk("rst_stall_req", cpu_stall_o, 1);
    @(negedge clk_i);
    rst_i = 1'b0;

    // clean load miss at 0x40
    #1;
    chk("miss_stall_same_cycle", cpu_stall_o, 1);
    chk("miss_idle_no_req", mem_req_o, 0);
    chk("miss_rdata_zero", cpu_rdata_o, 0);
    tick();
    chk("rf1_req", mem_req_o, 1);
    chk("rf1_we", mem_we_o, 0);
    chk("rf1_addr", mem_addr_o, 32'h40);
    chk("rf1_stall", cpu_stall_o, 1);
    l1 = mk_line(32'hA000_0000);
    l1[63:32] = 32'hDEAD_BEEF;
    mem_rdata_i = l1;
    mem_ack_i = 1'b1;
    #1;
    chk("rf1_ack_cycle_stall", cpu_stall_o, 1);
    tick();
    mem_ack_i = 1'b0;
    #1;
    chk("replay_stall", cpu_stall_o, 0);
    chk("replay_rdata", cpu_rdata_o, 32'hA000_0000);
    chk("replay_mem_req", mem_req_o, 0);
    cpu_addr_i = 32'h44;
    #1;
    chk("hit_w1_stall", cpu_stall_o, 0);
    chk("hit_w1_rdata", cpu_rdata_o, 32'hDEAD_BEEF);

    // store hit then load back
    cpu_we_i    = 1'b1;
    cpu_addr_i  = 32'h40;
    cpu_wdata_i = 32'h1234_5678;
    #1;
    chk("st_hit_stall", cpu_stall_o, 0);
    tick();
    cpu_we_i = 1'b0;
    #1;
    chk("st_readback", cpu_rdata_o, 32'h1234_5678);

    // conflicting load 0x240: write-back of dirty victim first
    cpu_addr_i = 32'h240;
    #1;
    chk("conf_stall", cpu_stall_o, 1);
    tick();
    chk("wb_req", mem_req_o, 1);
    chk("wb_we", mem_we_o, 1);
    chk("wb_addr", mem_addr_o, 32'h40);
    chk("wb_w0", mem_wdata_o[31:0], 32'h1234_5678);
    chk("wb_w1", mem_wdata_o[63:32], 32'hDEAD_BEEF);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    #1;
    chk("rf2_req", mem_req_o, 1);
    chk("rf2_we", mem_we_o, 0);
    chk("rf2_addr", mem_addr_o, 32'h240);
    chk("rf2_stall", cpu_stall_o, 1);
    mem_rdata_i = mk_line(32'hB000_0000);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    #1;
    chk("rf2_hit_stall", cpu_stall_o, 0);
    chk("rf2_hit_rdata", cpu_rdata_o, 32'hB000_0000);

    // store miss to invalid line at index 0
    cpu_we_i    = 1'b1;
    cpu_addr_i  = 32'h400;
    cpu_wdata_i = 32'h5555_AAAA;
    #1;
    chk("sm_stall", cpu_stall_o, 1);
    tick();
    chk("sm_no_wb", mem_we_o, 0);
    chk("sm_addr", mem_addr_o, 32'h400);
    mem_rdata_i = mk_line(32'hC000_0000);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    #1;
    chk("sm_replay_stall", cpu_stall_o, 0);
    tick();
    cpu_req_i = 1'b0;
    cpu_we_i  = 1'b0;

    // ack while idle must be ignored
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    #1;
    chk("idle_ack_ignored", mem_req_o, 0);

    // 0x600 evicts index 0; dirty from replayed store forces write-back
    cpu_req_i  = 1'b1;
    cpu_addr_i = 32'h600;
    #1;
    chk("ev0_stall", cpu_stall_o, 1);
    tick();
    chk("ev0_wb_we", mem_we_o, 1);
    chk("ev0_wb_addr", mem_addr_o, 32'h400);
    chk("ev0_wb_w0", mem_wdata_o[31:0], 32'h5555_AAAA);
    chk("ev0_wb_w1", mem_wdata_o[63:32], 32'hC000_0001);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk("slow_stall", cpu_stall_o, 1);
      chk("slow_req", mem_req_o, 1);
      chk("slow_addr", mem_addr_o, 32'h600);
      tick();
    end
    mem_rdata_i = mk_line(32'hD000_0000);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    #1;
    chk("slow_hit_stall", cpu_stall_o, 0);
    chk("slow_hit_rdata", cpu_rdata_o, 32'hD000_0000);

    // dirty index 2, then reset in the middle of its write-back
    cpu_we_i    = 1'b1;
    cpu_addr_i  = 32'h240;
    cpu_wdata_i = 32'h7777_7777;
    #1;
    chk("st2_hit_stall", cpu_stall_o, 0);
    tick();
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'h40;
    #1;
    chk("rst_case_stall", cpu_stall_o, 1);
    tick();
    chk("rst_case_wb_we", mem_we_o, 1);
    chk("rst_case_wb_addr", mem_addr_o, 32'h240);
    #1;
    rst_i = 1'b1;
    #1;
    chk("rst_async_mem_req", mem_req_o, 0);
    chk("rst_async_stall", cpu_stall_o, 1);
    #2;
    rst_i = 1'b0;
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    #1;
    chk("post_rst_req", mem_req_o, 1);
    chk("post_rst_clean_we", mem_we_o, 0);
    chk("post_rst_addr", mem_addr_o, 32'h40);
    mem_rdata_i = mk_line(32'hE000_0000);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    #1;
    chk("post_rst_hit_stall", cpu_stall_o, 0);
    chk("post_rst_hit_rdata", cpu_rdata_o, 32'hE000_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
